// File: rtl/mbe_r8_mul_arbiter.sv
// mbe_r8_mul_arbiter: round-robin sharing of one MBE radix-8 mantissa multiplier across NREQ requesters.
// Optional perf counters (grant_cnt, stall_cnt, perf_clr) are built when MBE_R8_ARB_PERF_EN is defined.
module top_MBE_R8 #(
   parameter int NBIT_MANTISSA = 23,
   parameter int NBLOCK        = 9,
   localparam int W            = NBIT_MANTISSA + 1
) (
   input  logic [W-1:0]   x,
   input  logic [W-1:0]   y,
   output logic [2*W-1:0] p
);
   localparam int YW = 3 * NBLOCK + 1;
   logic [YW-1:0]  y_ext;
   logic [W+1:0]   x3;
   logic [2*W-1:0] pp [NBLOCK];
   logic [2*W-1:0] acc;
   // Unsigned operand: zero-extend so the top Booth group always sees a non-negative digit.
   assign y_ext = {{(YW-W-1){1'b0}}, y, 1'b0};
   assign x3    = {2'b0, x} + {1'b0, x, 1'b0};
   for (genvar i = 0; i < NBLOCK; i++) begin : g_pp
      logic [3:0]   g;
      logic [2:0]   s;
      logic [2:0]   mag;
      logic [W+1:0] pm;
      assign g   = y_ext[3*i+3 -: 4];
      assign s   = {1'b0, g[2], 1'b0} + {2'b0, g[1]} + {2'b0, g[0]};
      assign mag = g[3] ? 3'd4 - s : s;
      assign pm  = mag == 3'd1 ? {2'b0, x} :
                   mag == 3'd2 ? {1'b0, x, 1'b0} :
                   mag == 3'd3 ? x3 :
                   mag == 3'd4 ? {x, 2'b0} : '0;
      assign pp[i] = g[3] ? -{{(W-2){1'b0}}, pm} : {{(W-2){1'b0}}, pm};
   end
   // Arithmetic is modulo 2^(2W); the true product always fits, so no guard bits are needed.
   always_comb begin
      acc = '0;
      for (int i = 0; i < NBLOCK; i++) acc = acc + (pp[i] << (3 * i));
   end
   assign p = acc;
endmodule

module mbe_r8_mul_arbiter #(
   parameter int NREQ          = 2,
   parameter int NBIT_MANTISSA = 23,
   parameter int NBLOCK        = 9,
   localparam int W            = NBIT_MANTISSA + 1,
   localparam int IW           = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_x,
   input  logic [NREQ*W-1:0] req_y,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [2*W-1:0]    res_p,
   output logic [IW-1:0]     res_id,
   output logic              busy
`ifdef MBE_R8_ARB_PERF_EN
   ,
   input  logic              perf_clr,
   output logic [NREQ*16-1:0] grant_cnt,
   output logic [15:0]       stall_cnt
`endif
);
   logic            op_v;
   logic [W-1:0]    op_x;
   logic [W-1:0]    op_y;
   logic [IW-1:0]   op_id;
   logic [IW-1:0]   rr_ptr;
   logic [NREQ-1:0] grant;
   logic [IW-1:0]   win;
   logic            found;
   logic [IW:0]     sum;
   logic [IW-1:0]   idx;
   logic            s0_en;
   logic            s1_en;
   logic            hs;
   logic [2*W-1:0]  prod;
   always_comb begin
      grant = '0;
      win   = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr} + (IW+1)'(k);
         idx = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = idx;
         end
      end
   end
   assign s1_en     = op_v & (!res_valid | res_ready);
   assign s0_en     = !op_v | s1_en;
   // Gated by rst_n so the handshake is dead the instant reset asserts.
   assign req_ready = (s0_en & rst_n) ? grant : '0;
   assign hs        = |req_ready;
   assign busy      = op_v | res_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_v   <= 1'b0;
         op_x   <= '0;
         op_y   <= '0;
         op_id  <= '0;
         rr_ptr <= '0;
      end else if (s0_en) begin
         op_v <= hs;
         if (hs) begin
            op_x   <= req_x[win*W +: W];
            op_y   <= req_y[win*W +: W];
            op_id  <= win;
            rr_ptr <= win == IW'(NREQ-1) ? '0 : win + 1'b1;
         end
      end
   end
   top_MBE_R8 #(.NBIT_MANTISSA(NBIT_MANTISSA), .NBLOCK(NBLOCK)) u_mul (
      .x(op_x),
      .y(op_y),
      .p(prod)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_p     <= '0;
         res_id    <= '0;
      end else if (s1_en) begin
         res_valid <= 1'b1;
         res_p     <= prod;
         res_id    <= op_id;
      end else if (res_valid & res_ready) begin
         res_valid <= 1'b0;
      end
   end
`ifdef MBE_R8_ARB_PERF_EN
   for (genvar g = 0; g < NREQ; g++) begin : g_gcnt
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) grant_cnt[g*16 +: 16] <= '0;
         else if (perf_clr) grant_cnt[g*16 +: 16] <= '0;
         else if (req_ready[g] && grant_cnt[g*16 +: 16] != 16'hFFFF) grant_cnt[g*16 +: 16] <= grant_cnt[g*16 +: 16] + 16'd1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt <= '0;
      else if (perf_clr) stall_cnt <= '0;
      else if (res_valid && !res_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_mbe_r8_mul_arbiter.sv
// tb_mbe_r8_mul_arbiter: directed and randomized checks of the shared-multiplier arbiter against a behavioural model.
module tb_mbe_r8_mul_arbiter;
   localparam int NREQ = 2;
   localparam int W    = 24;
   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_x;
   logic [NREQ*W-1:0] req_y;
   logic              res_valid;
   logic              res_ready;
   logic [2*W-1:0]    res_p;
   logic              res_id;
   logic              busy;
`ifdef MBE_R8_ARB_PERF_EN
   logic              perf_clr = 1'b0;
   logic [NREQ*16-1:0] grant_cnt;
   logic [15:0]       stall_cnt;
`endif
   mbe_r8_mul_arbiter #(.NREQ(NREQ), .NBIT_MANTISSA(23), .NBLOCK(9)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_x(req_x),
      .req_y(req_y),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_p(res_p),
      .res_id(res_id),
      .busy(busy)
`ifdef MBE_R8_ARB_PERF_EN
      ,
      .perf_clr(perf_clr),
      .grant_cnt(grant_cnt),
      .stall_cnt(stall_cnt)
`endif
   );
   always #5 clk = ~clk;
   int n_checks = 0;
   int n_errors = 0;
   logic [NREQ-1:0] pend;
   logic [W-1:0]    px [NREQ];
   logic [W-1:0]    py [NREQ];
   // reference model: a two-slot pipeline of (id, product) items plus a round-robin pointer
   logic            m_opv, m_rv;
   int              m_opid, m_rid, m_ptr;
   logic [2*W-1:0]  m_opp, m_rp;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic drv();
      req_valid = pend;
      for (int i = 0; i < NREQ; i++) begin
         req_x[i*W +: W] = px[i];
         req_y[i*W +: W] = py[i];
      end
   endtask
   task automatic model_reset();
      m_opv = 0; m_rv = 0; m_opid = 0; m_rid = 0; m_ptr = 0; m_opp = '0; m_rp = '0;
   endtask
   task automatic step();
      logic [NREQ-1:0] er;
      logic adv;
      int w;
      drv();
      @(negedge clk);
      er = '0;
      w = -1;
      if (!(m_rv && !res_ready && m_opv))
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && pend[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) er[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("res_valid", 64'(res_valid), 64'(m_rv));
      chk("busy", 64'(busy), 64'(m_opv | m_rv));
      if (m_rv) begin
         chk("res_p", 64'(res_p), 64'(m_rp));
         chk("res_id", 64'(res_id), 64'(m_rid));
      end
      adv = m_opv && (!m_rv || res_ready);
      if (adv) begin
         m_rv = 1; m_rp = m_opp; m_rid = m_opid;
      end else if (m_rv && res_ready) m_rv = 0;
      if (!m_opv || adv) begin
         m_opv = (w >= 0);
         if (w >= 0) begin
            m_opid = w;
            m_opp  = {24'b0, px[w]} * {24'b0, py[w]};
            m_ptr  = (w + 1) % NREQ;
         end
      end
      @(posedge clk);
      #1;
      pend = pend & ~er;
      drv();
   endtask
   function automatic logic [W-1:0] rnd_op();
      int s = $urandom_range(0, 5);
      return s == 0 ? 24'h000000 : s == 1 ? 24'hFFFFFF : s == 2 ? 24'h800000 : W'($urandom);
   endfunction
   initial begin
      rst_n = 1'b0;
      res_ready = 1'b1;
      pend = '0;
      for (int i = 0; i < NREQ; i++) begin px[i] = '0; py[i] = '0; end
      drv();
      model_reset();
      #1;
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_res_p", 64'(res_p), 0);
      chk("rst_res_id", 64'(res_id), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_req_ready", 64'(req_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // single op
      pend[0] = 1; px[0] = 24'h800000; py[0] = 24'h800000;
      step(); step();
      chk("single_valid", 64'(res_valid), 1);
      chk("single_p", 64'(res_p), 64'h400000000000);
      chk("single_id", 64'(res_id), 0);
      step();
      chk("single_busy_c3", 64'(busy), 0);
      // max operands
      pend[1] = 1; px[1] = 24'hFFFFFF; py[1] = 24'hFFFFFF;
      step(); step();
      chk("max_p", 64'(res_p), 64'hFFFFFE000001);
      chk("max_id", 64'(res_id), 1);
      step();
      // fairness
`ifdef MBE_R8_ARB_PERF_EN
      perf_clr = 1'b1;
`endif
      step();
`ifdef MBE_R8_ARB_PERF_EN
      perf_clr = 1'b0;
`endif
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < NREQ; i++) if (!pend[i]) begin px[i] = W'($urandom); py[i] = W'($urandom); end
         pend = '1;
         drv();
         #1 chk("fair_grant", 64'(req_ready), 64'(1 << (k % 2)));
         step();
      end
      pend = '0;
      repeat (3) step();
`ifdef MBE_R8_ARB_PERF_EN
      chk("fair_grant_cnt", 64'(grant_cnt), 64'h0003_0003);
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
`endif
      // backpressure
      pend[0] = 1; px[0] = 24'h123456; py[0] = 24'h000010;
      step();
      pend[1] = 1; px[1] = 24'hC00000; py[1] = 24'h800000;
      step();
      res_ready = 1'b0;
      pend[0] = 1; px[0] = 24'h000003; py[0] = 24'h000005;
      for (int k = 0; k < 5; k++) begin
         drv();
         #1;
         chk("bp_valid", 64'(res_valid), 1);
         chk("bp_p", 64'(res_p), 64'h1234560);
         chk("bp_id", 64'(res_id), 0);
         chk("bp_ready", 64'(req_ready), 0);
         step();
      end
      res_ready = 1'b1;
      drv();
      #1 chk("bp_release_ready", 64'(req_ready), 1);
      step();
      chk("bp_second_p", 64'(res_p), 64'h600000000000);
      chk("bp_second_id", 64'(res_id), 1);
`ifdef MBE_R8_ARB_PERF_EN
      chk("bp_stall_cnt", 64'(stall_cnt), 5);
      perf_clr = 1'b1;
      step();
      perf_clr = 1'b0;
      chk("clr_stall_cnt", 64'(stall_cnt), 0);
      chk("clr_grant_cnt", 64'(grant_cnt), 0);
`endif
      repeat (3) step();
      // reset mid-flight
      pend[0] = 1; px[0] = 24'h00ABCD; py[0] = 24'h000777;
      step();
      pend = '1;
      drv();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(res_valid), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_ready", 64'(req_ready), 0);
      chk("mid_rst_p", 64'(res_p), 0);
      chk("mid_rst_id", 64'(res_id), 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("post_rst_grant", 64'(req_ready), 1);
      repeat (4) step();
      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++)
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1; px[i] = rnd_op(); py[i] = rnd_op();
            end
         res_ready = $urandom_range(0, 3) != 0;
         step();
      end
      pend = '0;
      res_ready = 1'b1;
      repeat (4) step();
      chk("final_busy", 64'(busy), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
